probe_sweep_ctl: RTL and testbench

Sequences a probe X-sweep from the probe mode register produced by the keyboard-driven probe state machine (`PRB_ST`, `CLR_XPOS`). For each X position it runs four steps:
- waits a settle time;
- requests one sample from the acquisition front end over a REQ/DONE handshake;
- writes the result into the display sample RAM;
- advances X.

Mode 3 runs a single sweep, mode 4 runs continuous sweeps, and `CLR_XPOS` aborts and rewinds.

---
 rtl/probe_pkg.sv | 25 ++
 rtl/prb_dcnt.sv | 32 +++
 rtl/probe_sweep_ctl.sv | 169 ++++++++++++++++
 tb/tb_probe_sweep_ctl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/probe_pkg.sv
// Shared probe definitions: mode codes used by the keyboard probe state machine
// and the X-sweep sequencer state encoding.
package probe_pkg;

  localparam logic [2:0] PRB_IDLE   = 3'd0;
  localparam logic [2:0] PRB_ARM    = 3'd1;
  localparam logic [2:0] PRB_CLR    = 3'd2;
  localparam logic [2:0] PRB_SINGLE = 3'd3;
  localparam logic [2:0] PRB_CONT   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_REQ    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_NEXT   = 3'd5
  } sweep_state_t;

  // Only the two sweep modes keep the sequencer running.
  function automatic logic is_sweep_mode(input logic [2:0] mode);
    return (mode == PRB_SINGLE) || (mode == PRB_CONT);
  endfunction

endpackage

// File: rtl/prb_dcnt.sv
// 8-bit loadable down-counter with a zero flag; stops at zero.
module prb_dcnt (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 8'd0);

endmodule

// File: rtl/probe_sweep_ctl.sv
// Probe X-sweep sequencer: settle, request a sample, write it to the display RAM,
// advance X. Mode 3 sweeps once, mode 4 sweeps continuously, CLR_XPOS rewinds.
module probe_sweep_ctl
  import probe_pkg::*;
#(
  parameter int XPOS_W     = 10,
  parameter int XPOS_MAX   = 639,
  parameter int DATA_W     = 8,
  parameter int SETTLE_CYC = 16,
  parameter int TMO_CYC    = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [2:0]        PRB_ST,
  input  logic              CLR_XPOS,
  output logic              SMP_REQ,
  input  logic              SMP_DONE,
  input  logic [DATA_W-1:0] SMP_DATA,
  output logic              WR_EN,
  output logic [XPOS_W-1:0] WR_ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  output logic [XPOS_W-1:0] XPOS,
  output logic              BUSY,
  output logic              SWEEP_DONE,
  output logic              SMP_TMO,
  output logic [2:0]        DBG_STATE
);

  localparam logic [XPOS_W-1:0] XMAX       = XPOS_W'(XPOS_MAX);
  localparam logic [7:0]        SETTLE_LD  = 8'(SETTLE_CYC - 1);
  localparam logic [7:0]        TMO_LD     = 8'(TMO_CYC - 1);

  sweep_state_t      state_q, state_d;
  logic [XPOS_W-1:0] xpos_q, xpos_d;
  logic [XPOS_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              tmo_q, tmo_d;
  logic              req_q, wr_en_q, busy_q, done_q;
  logic              settle_load, settle_dec, settle_zero;
  logic              tmo_load, tmo_dec, tmo_zero;
  logic              run;

  prb_dcnt u_settle_cnt (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (settle_load),
    .load_val_i (SETTLE_LD),
    .dec_i      (settle_dec),
    .zero_o     (settle_zero)
  );

  prb_dcnt u_tmo_cnt (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (tmo_load),
    .load_val_i (TMO_LD),
    .dec_i      (tmo_dec),
    .zero_o     (tmo_zero)
  );

  assign run = is_sweep_mode(PRB_ST);

  // Handshake: SMP_REQ is a one-cycle pulse in REQ; the front end answers with
  // SMP_DONE (SMP_DATA valid in that cycle) any time during WAIT. SMP_DONE seen in
  // any other state is ignored, and a missing answer times out to a zero sample.
  always_comb begin
    state_d     = state_q;
    xpos_d      = xpos_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    tmo_d       = tmo_q;
    settle_load = 1'b0;
    settle_dec  = 1'b0;
    tmo_load    = 1'b0;
    tmo_dec     = 1'b0;
    if (CLR_XPOS) begin
      state_d = ST_IDLE;
      xpos_d  = '0;
      tmo_d   = 1'b0;
    end else if ((state_q != ST_IDLE) && !run) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_d     = ST_SETTLE;
            settle_load = 1'b1;
          end
        end
        ST_SETTLE: begin
          if (settle_zero) state_d = ST_REQ;
          else             settle_dec = 1'b1;
        end
        ST_REQ: begin
          tmo_load = 1'b1;
          state_d  = ST_WAIT;
        end
        ST_WAIT: begin
          // A strobe on the expiry cycle counts as a good sample.
          if (SMP_DONE) begin
            wr_data_d = SMP_DATA;
            wr_addr_d = xpos_q;
            state_d   = ST_WRITE;
          end else if (tmo_zero) begin
            wr_data_d = '0;
            wr_addr_d = xpos_q;
            tmo_d     = 1'b1;
            state_d   = ST_WRITE;
          end else begin
            tmo_dec = 1'b1;
          end
        end
        ST_WRITE: state_d = ST_NEXT;
        ST_NEXT: begin
          if (xpos_q == XMAX) begin
            xpos_d = '0;
            if (PRB_ST == PRB_CONT) begin
              state_d     = ST_SETTLE;
              settle_load = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            xpos_d      = xpos_q + 1'b1;
            state_d     = ST_SETTLE;
            settle_load = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Strobes are registered from the next state so they line up with state entry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      xpos_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      tmo_q     <= 1'b0;
      req_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      xpos_q    <= xpos_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      tmo_q     <= tmo_d;
      req_q     <= (state_d == ST_REQ);
      wr_en_q   <= (state_d == ST_WRITE);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_NEXT) && (xpos_q == XMAX);
    end
  end

  assign SMP_REQ    = req_q;
  assign WR_EN      = wr_en_q;
  assign WR_ADDR    = wr_addr_q;
  assign WR_DATA    = wr_data_q;
  assign XPOS       = xpos_q;
  assign BUSY       = busy_q;
  assign SWEEP_DONE = done_q;
  assign SMP_TMO    = tmo_q;
  assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_probe_sweep_ctl.sv
// Self-checking bench for probe_sweep_ctl: front-end responder model, RAM write
// scoreboard fed from an expected queue, and one task per scenario.
module tb_probe_sweep_ctl;
  import probe_pkg::*;

  localparam int XW     = 10;
  localparam int DW     = 8;
  localparam int XMAX   = 3;
  localparam int SETTLE = 4;
  localparam int TMO    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    prb_st;
  logic          clr_xpos;
  logic          smp_req;
  logic          smp_done;
  logic [DW-1:0] smp_data;
  logic          wr_en;
  logic [XW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [XW-1:0] xpos;
  logic          busy;
  logic          sweep_done;
  logic          smp_tmo;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  logic [XW+DW-1:0] exp_q[$];
  int req_t[$];
  int done_t[$];
  int wr_cnt = 0;
  int cyc = 0;

  int            resp_en = 1;
  int            resp_delay = 1;
  int            resp_skip = -1;
  logic          resp_fixed_en = 1'b0;
  logic [DW-1:0] resp_fixed = 8'hAA;
  int            pend = 0;
  logic [DW-1:0] pend_data;

  probe_sweep_ctl #(
    .XPOS_W(XW), .XPOS_MAX(XMAX), .DATA_W(DW), .SETTLE_CYC(SETTLE), .TMO_CYC(TMO)
  ) dut (
    .CLK(clk), .RST(rst), .PRB_ST(prb_st), .CLR_XPOS(clr_xpos),
    .SMP_REQ(smp_req), .SMP_DONE(smp_done), .SMP_DATA(smp_data),
    .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data), .XPOS(xpos),
    .BUSY(busy), .SWEEP_DONE(sweep_done), .SMP_TMO(smp_tmo), .DBG_STATE(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- front-end responder ----------------
  always @(negedge clk) begin
    smp_done = 1'b0;
    smp_data = DW'($urandom);
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        smp_done = 1'b1;
        smp_data = pend_data;
      end
    end
    if (smp_req && (resp_en != 0) && (int'(xpos) != resp_skip)) begin
      pend      = resp_delay;
      pend_data = resp_fixed_en ? resp_fixed : (8'h10 + DW'(xpos));
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (wr_en) begin
      logic [XW+DW-1:0] exp_v;
      wr_cnt = wr_cnt + 1;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL wr_unexpected: got addr=%0d data=%0h, required no write", wr_addr, wr_data);
      end else begin
        exp_v = exp_q.pop_front();
        if ({wr_addr, wr_data} !== exp_v)
          begin
            errors = errors + 1;
            $display("FAIL wr_data: got addr=%0d data=%0h, required addr=%0d data=%0h",
                     wr_addr, wr_data, exp_v[XW+DW-1:DW], exp_v[DW-1:0]);
          end
      end
    end
    if (smp_req)    req_t.push_back(cyc);
    if (sweep_done) done_t.push_back(cyc);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_hist();
    req_t.delete();
    done_t.delete();
    wr_cnt = 0;
  endtask

  task automatic push_sweep(input int skip_x, input logic fixed, input logic [DW-1:0] fval);
    for (int x = 0; x <= XMAX; x++) begin
      logic [DW-1:0] d;
      d = fixed ? fval : (8'h10 + DW'(x));
      if (x == skip_x) d = '0;
      exp_q.push_back({XW'(x), d});
    end
  endtask

  task automatic wait_done(input int n, input string tag);
    for (int i = 0; i < 400 && done_t.size() < n; i++) step();
    checks++;
    if (done_t.size() < n) begin
      errors++;
      $display("FAIL %s_done_timeout: got %0d sweep_done pulses, required %0d", tag, done_t.size(), n);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; prb_st = PRB_IDLE; clr_xpos = 1'b0;
    repeat (3) step();
    checks++; if (smp_req !== 1'b0)    begin errors++; $display("FAIL reset_smp_req: got %b, required 0", smp_req); end
    checks++; if (wr_en !== 1'b0)      begin errors++; $display("FAIL reset_wr_en: got %b, required 0", wr_en); end
    checks++; if (wr_addr !== '0)      begin errors++; $display("FAIL reset_wr_addr: got %0d, required 0", wr_addr); end
    checks++; if (wr_data !== '0)      begin errors++; $display("FAIL reset_wr_data: got %0h, required 0", wr_data); end
    checks++; if (xpos !== '0)         begin errors++; $display("FAIL reset_xpos: got %0d, required 0", xpos); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL reset_sweep_done: got %b, required 0", sweep_done); end
    checks++; if (smp_tmo !== 1'b0)    begin errors++; $display("FAIL reset_smp_tmo: got %b, required 0", smp_tmo); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d, required 0", dbg_state); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int start;
    clear_hist();
    resp_delay = 1; resp_skip = -1; resp_fixed_en = 1'b0;
    push_sweep(-1, 1'b0, '0);
    start = cyc;
    prb_st = PRB_SINGLE;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_start: got %b, required 1", busy); end
    wait_done(1, "single");
    step();
    prb_st = PRB_IDLE;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b, required 0", busy); end
    checks++; if (xpos !== '0)   begin errors++; $display("FAIL single_xpos_wrap: got %0d, required 0", xpos); end
    checks++;
    if (req_t.size() != 4) begin
      errors++; $display("FAIL single_req_count: got %0d, required 4", req_t.size());
    end else begin
      checks++;
      if (req_t[0] != start + 1 + SETTLE) begin
        errors++; $display("FAIL single_first_req: got cycle %0d, required %0d", req_t[0], start + 1 + SETTLE);
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (req_t[i] - req_t[i-1] != SETTLE + 4) begin
          errors++; $display("FAIL single_period: got %0d, required %0d", req_t[i] - req_t[i-1], SETTLE + 4);
        end
      end
      if (done_t.size() > 0) begin
        checks++;
        if (done_t[0] != req_t[3] + 3) begin
          errors++; $display("FAIL single_done_cycle: got %0d, required %0d", done_t[0], req_t[3] + 3);
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_missing_writes: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_continuous();
    clear_hist();
    push_sweep(-1, 1'b0, '0);
    push_sweep(-1, 1'b0, '0);
    exp_q.push_back({XW'(0), 8'h10});
    exp_q.push_back({XW'(1), 8'h11});
    prb_st = PRB_CONT;
    for (int i = 0; i < 400 && wr_cnt < 10; i++) step();
    checks++;
    if (wr_cnt < 10) begin errors++; $display("FAIL cont_timeout: got %0d writes, required 10", wr_cnt); end
    prb_st = PRB_IDLE;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_abort_busy: got %b, required 0", busy); end
    checks++; if (xpos !== XW'(1)) begin errors++; $display("FAIL cont_abort_xpos: got %0d, required 1", xpos); end
    checks++;
    if (done_t.size() != 2 || req_t.size() < 5) begin
      errors++; $display("FAIL cont_counts: got %0d done %0d req, required 2 done >=5 req", done_t.size(), req_t.size());
    end else begin
      checks++;
      if (req_t[4] - done_t[0] != SETTLE + 1) begin
        errors++; $display("FAIL cont_wrap_gap: got %0d, required %0d", req_t[4] - done_t[0], SETTLE + 1);
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL cont_missing_writes: got %0d left, required 0", exp_q.size()); end
    clr_xpos = 1'b1;
    step();
    clr_xpos = 1'b0;
    checks++; if (xpos !== '0) begin errors++; $display("FAIL cont_clear_xpos: got %0d, required 0", xpos); end
  endtask

  task automatic test_timeout();
    clear_hist();
    resp_skip = 2;
    push_sweep(2, 1'b0, '0);
    prb_st = PRB_SINGLE;
    for (int i = 0; i < 100 && wr_cnt < 2; i++) step();
    checks++; if (smp_tmo !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b, required 0", smp_tmo); end
    wait_done(1, "tmo");
    step();
    prb_st = PRB_IDLE;
    checks++; if (smp_tmo !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b, required 1", smp_tmo); end
    checks++;
    if (req_t.size() != 4) begin
      errors++; $display("FAIL tmo_req_count: got %0d, required 4", req_t.size());
    end else begin
      checks++;
      if (req_t[3] - req_t[2] != SETTLE + 3 + TMO) begin
        errors++; $display("FAIL tmo_period: got %0d, required %0d", req_t[3] - req_t[2], SETTLE + 3 + TMO);
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL tmo_missing_writes: got %0d left, required 0", exp_q.size()); end
    resp_skip = -1;
    clr_xpos = 1'b1;
    step();
    clr_xpos = 1'b0;
    checks++; if (smp_tmo !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b, required 0", smp_tmo); end
  endtask

  task automatic test_expiry();
    clear_hist();
    resp_delay = TMO; resp_fixed_en = 1'b1; resp_fixed = 8'hAA;
    push_sweep(-1, 1'b1, 8'hAA);
    prb_st = PRB_SINGLE;
    wait_done(1, "expiry");
    step();
    prb_st = PRB_IDLE;
    checks++; if (smp_tmo !== 1'b0) begin errors++; $display("FAIL expiry_tmo: got %b, required 0", smp_tmo); end
    checks++;
    if (req_t.size() < 2) begin
      errors++; $display("FAIL expiry_req_count: got %0d, required 4", req_t.size());
    end else begin
      checks++;
      if (req_t[1] - req_t[0] != SETTLE + 3 + TMO) begin
        errors++; $display("FAIL expiry_period: got %0d, required %0d", req_t[1] - req_t[0], SETTLE + 3 + TMO);
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL expiry_missing_writes: got %0d left, required 0", exp_q.size()); end
    resp_delay = 1; resp_fixed_en = 1'b0;
  endtask

  task automatic test_clear_wait();
    clear_hist();
    resp_delay = 3;
    exp_q.push_back({XW'(0), 8'h10});
    exp_q.push_back({XW'(1), 8'h11});
    prb_st = PRB_SINGLE;
    for (int i = 0; i < 200 && req_t.size() < 3; i++) step();
    checks++;
    if (req_t.size() < 3) begin errors++; $display("FAIL clr_timeout: got %0d requests, required 3", req_t.size()); end
    step();
    clr_xpos = 1'b1;
    prb_st = PRB_IDLE;
    step();
    clr_xpos = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b, required 0", busy); end
    checks++; if (xpos !== '0) begin errors++; $display("FAIL clr_xpos: got %0d, required 0", xpos); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL clr_state: got %0d, required 0", dbg_state); end
    repeat (10) step();
    checks++; if (wr_cnt != 2) begin errors++; $display("FAIL clr_writes: got %0d, required 2", wr_cnt); end
    checks++; if (req_t.size() != 3) begin errors++; $display("FAIL clr_extra_req: got %0d, required 3", req_t.size()); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL clr_missing_writes: got %0d left, required 0", exp_q.size()); end
    resp_delay = 1;
  endtask

  task automatic test_abort_settle();
    clear_hist();
    push_sweep(-1, 1'b0, '0);
    prb_st = PRB_SINGLE;
    for (int i = 0; i < 100 && wr_cnt < 1; i++) step();
    step();
    step();
    checks++; if (xpos !== XW'(1)) begin errors++; $display("FAIL abort_pre_xpos: got %0d, required 1", xpos); end
    prb_st = PRB_ARM;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, required 0", busy); end
    checks++; if (xpos !== XW'(1)) begin errors++; $display("FAIL abort_xpos: got %0d, required 1", xpos); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL abort_state: got %0d, required 0", dbg_state); end
    repeat (3) step();
    prb_st = PRB_SINGLE;
    wait_done(1, "abort");
    step();
    prb_st = PRB_IDLE;
    checks++; if (req_t.size() != 4) begin errors++; $display("FAIL abort_req_count: got %0d, required 4", req_t.size()); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL abort_missing_writes: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    clear_hist();
    exp_q.push_back({XW'(0), 8'h10});
    prb_st = PRB_SINGLE;
    for (int i = 0; i < 100 && req_t.size() < 2; i++) step();
    rst = 1'b1;
    #1;
    checks++; if (smp_req !== 1'b0) begin errors++; $display("FAIL rstmid_req: got %b, required 0", smp_req); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    checks++; if (xpos !== '0)      begin errors++; $display("FAIL rstmid_xpos: got %0d, required 0", xpos); end
    prb_st = PRB_IDLE;
    step();
    step();
    rst = 1'b0;
    repeat (8) step();
    checks++; if (wr_cnt != 1) begin errors++; $display("FAIL rstmid_writes: got %0d, required 1", wr_cnt); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_missing_writes: got %0d left, required 0", exp_q.size()); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst = 1'b1; prb_st = PRB_IDLE; clr_xpos = 1'b0;
    smp_done = 1'b0; smp_data = '0;
    test_reset();
    test_single();
    test_continuous();
    test_timeout();
    test_expiry();
    test_clear_wait();
    test_abort_settle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
